// File: rtl/cpu_seq_ctrl_if.sv
// Bundle between the sequencer and the datapath it controls: the decoder
// control fields and the shared memory-port handshake going in, and the
// strobes and status coming out.
interface cpu_seq_ctrl_if;
    // decoder control bundle and run control
    logic        dec_reg_write_en;
    logic        dec_mem_write_en;
    logic        dec_mem2reg_en;
    logic [7:0]  dec_exception;
    logic        halt;
    // shared memory port
    logic        mem_ack;
    logic        mem_req;
    logic        mem_we;
    logic        mem_is_fetch;
    // datapath strobes and status
    logic        ir_load;
    logic        rf_write;
    logic        pc_write;
    logic        trap_valid;
    logic [7:0]  trap_code;
    logic        retire;
    logic [31:0] instret;
    logic        halted;

    // datapath / memory side
    modport master (
        output dec_reg_write_en, dec_mem_write_en, dec_mem2reg_en, dec_exception,
        output halt, mem_ack,
        input  mem_req, mem_we, mem_is_fetch, ir_load, rf_write, pc_write,
        input  trap_valid, trap_code, retire, instret, halted
    );

    // sequencer side
    modport slave (
        input  dec_reg_write_en, dec_mem_write_en, dec_mem2reg_en, dec_exception,
        input  halt, mem_ack,
        output mem_req, mem_we, mem_is_fetch, ir_load, rf_write, pc_write,
        output trap_valid, trap_code, retire, instret, halted
    );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle MIPS sequencer: fetch, decode settle, optional memory phase,
// commit. Shares one memory port between fetch and load/store and turns
// decoder exceptions and memory timeouts into a one-cycle trap strobe.
module cpu_seq_ctrl #(
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter logic [7:0]  BUS_ERR_CODE = 8'h03
) (
    input  logic          clk,
    input  logic          rst_n,
    cpu_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP, S_HALTED
    } state_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  r_trap_code;
    logic [31:0] r_instret;
    logic        w_mem_phase;
    logic        w_timeout;

    logic        w_mem_req;
    logic        w_mem_we;
    logic        w_mem_is_fetch;
    logic        w_rf_write;
    logic        w_pc_write;
    logic        w_trap_valid;
    logic        w_retire;
    logic        w_halted;

    // A request is outstanding in FETCH and MEM; an ack on the limit cycle wins.
    assign w_mem_phase = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_timeout   = w_mem_phase && !bus.mem_ack && (r_wait_cnt == TIMEOUT_LIM);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_BOOT;
        else        r_state <= w_state_next;
    end

    // Wait counter: counts unacked request cycles, cleared in any non-memory
    // state so it starts from zero on every entry to FETCH or MEM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         r_wait_cnt <= 8'd0;
        else if (w_mem_phase && !bus.mem_ack) r_wait_cnt <= r_wait_cnt + 8'd1;
        else                                r_wait_cnt <= 8'd0;
    end

    // Trap cause: decoder code captured in DECODE, bus error on timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    r_trap_code <= 8'h00;
        else if (r_state == S_DECODE)  r_trap_code <= bus.dec_exception;
        else if (w_timeout)            r_trap_code <= BUS_ERR_CODE;
    end

    // Retired-instruction counter, wraps naturally at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               r_instret <= 32'd0;
        else if (r_state == S_WB) r_instret <= r_instret + 32'd1;
    end

    // Next-state and Moore output decode
    always_comb begin
        w_state_next   = r_state;
        w_mem_req      = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_is_fetch = 1'b0;
        w_rf_write     = 1'b0;
        w_pc_write     = 1'b0;
        w_trap_valid   = 1'b0;
        w_retire       = 1'b0;
        w_halted       = 1'b0;
        case (r_state)
            S_BOOT: w_state_next = S_FETCH;
            S_FETCH: begin
                w_mem_req      = 1'b1;
                w_mem_is_fetch = 1'b1;
                if (bus.mem_ack)    w_state_next = S_DECODE;
                else if (w_timeout) w_state_next = S_TRAP;
            end
            S_DECODE: begin
                if (bus.dec_exception != 8'h00) w_state_next = S_TRAP;
                else                            w_state_next = S_EXEC;
            end
            S_EXEC: begin
                if (bus.dec_mem_write_en || bus.dec_mem2reg_en) w_state_next = S_MEM;
                else                                            w_state_next = S_WB;
            end
            S_MEM: begin
                w_mem_req = 1'b1;
                w_mem_we  = bus.dec_mem_write_en;
                if (bus.mem_ack)    w_state_next = S_WB;
                else if (w_timeout) w_state_next = S_TRAP;
            end
            S_WB: begin
                w_rf_write   = bus.dec_reg_write_en;
                w_pc_write   = 1'b1;
                w_retire     = 1'b1;
                w_state_next = bus.halt ? S_HALTED : S_FETCH;
            end
            S_TRAP: begin
                w_trap_valid = 1'b1;
                w_pc_write   = 1'b1;
                w_state_next = bus.halt ? S_HALTED : S_FETCH;
            end
            S_HALTED: begin
                w_halted = 1'b1;
                if (!bus.halt) w_state_next = S_FETCH;
            end
            default: w_state_next = S_BOOT;
        endcase
    end

    assign bus.mem_req      = w_mem_req;
    assign bus.mem_we       = w_mem_we;
    assign bus.mem_is_fetch = w_mem_is_fetch;
    assign bus.ir_load      = bus.mem_ack && (r_state == S_FETCH);
    assign bus.rf_write     = w_rf_write;
    assign bus.pc_write     = w_pc_write;
    assign bus.trap_valid   = w_trap_valid;
    assign bus.trap_code    = w_trap_valid ? r_trap_code : 8'h00;
    assign bus.retire       = w_retire;
    assign bus.instret      = r_instret;
    assign bus.halted       = w_halted;
endmodule
